channel_scheduler: RTL and testbench

- Shares one parallel channel "A" engine among NUM_REQ requesters: host port, boot loader, diagnostics and so on.
- Arbitrates start requests round-robin, drives the engine's address/command/count/start_strobe, and steers the send/receive AXI-Stream data to the granted requester.
- Returns final status and residual count through a per-requester completion handshake.
- Sits directly between the requesters and the channel engine.

---
 rtl/channel_pkg.sv | 22 ++
 rtl/channel_scheduler_rr_arbiter.sv | 34 +++
 rtl/channel_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_channel_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared constants for the channel A scheduler: FSM state encoding, engine status bits
// and the default start timeout.
package channel_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_START       = 3'd1;
  localparam logic [2:0] ST_WAIT_ACTIVE = 3'd2;
  localparam logic [2:0] ST_BUSY        = 3'd3;
  localparam logic [2:0] ST_DONE        = 3'd4;

  localparam int STATUS_BUSY = 3;
  localparam int STATUS_CE   = 4;
  localparam int STATUS_DE   = 5;

  localparam int DEFAULT_START_TIMEOUT = 16;
  localparam int MAX_RETRIES           = 3;

  function automatic logic is_busy(input logic [7:0] status);
    return status[STATUS_BUSY];
  endfunction

endpackage

// File: rtl/channel_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward from
// last_grant_i+1 with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_o
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // Walk the requesters in priority order, keeping the first hit.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
      if (!found_s && req_i[idx_s]) begin
        found_s = 1'b1;
        grant_o = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/channel_scheduler.sv
// Shares one channel A engine among NUM_REQ requesters: round-robin start arbitration,
// stream steering and per-requester completion. Option: CHANNEL_SCHEDULER_BUSY_RETRY_EN.
module channel_scheduler
  import channel_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_address,
  input  logic [8*NUM_REQ-1:0]   req_command,
  input  logic [8*NUM_REQ-1:0]   req_count,
  output logic [NUM_REQ-1:0]     done_valid,
  input  logic [NUM_REQ-1:0]     done_ready,
  output logic [7:0]             done_status,
  output logic [7:0]             done_res_count,
  output logic                   done_error,
  output logic [7:0]             ch_address,
  output logic [7:0]             ch_command,
  output logic [7:0]             ch_count,
  output logic                   ch_start_strobe,
  input  logic                   ch_active,
  input  logic [7:0]             ch_status,
  input  logic                   ch_status_strobe,
  input  logic [7:0]             ch_res_count,
  output logic [7:0]             ch_send_tdata,
  output logic                   ch_send_tvalid,
  input  logic                   ch_send_tready,
  input  logic [7:0]             ch_recv_tdata,
  input  logic                   ch_recv_tvalid,
  output logic                   ch_recv_tready,
  input  logic [8*NUM_REQ-1:0]   send_tdata,
  input  logic [NUM_REQ-1:0]     send_tvalid,
  output logic [NUM_REQ-1:0]     send_tready,
  output logic [7:0]             recv_tdata,
  output logic [NUM_REQ-1:0]     recv_tvalid,
  input  logic [NUM_REQ-1:0]     recv_tready
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [7:0] addr_a [NUM_REQ];
  logic [7:0] cmd_a  [NUM_REQ];
  logic [7:0] cnt_a  [NUM_REQ];
  logic [7:0] sdata_a[NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_address[8*g +: 8];
    assign cmd_a[g]   = req_command[8*g +: 8];
    assign cnt_a[g]   = req_count[8*g +: 8];
    assign sdata_a[g] = send_tdata[8*g +: 8];
  end

  logic [2:0]         state_d, state_q;
  logic [IDX_W-1:0]   grant_d, grant_q, last_grant_d, last_grant_q;
  logic [NUM_REQ-1:0] req_ready_d, req_ready_q, done_valid_d, done_valid_q;
  logic [7:0]         status_d, status_q, res_count_d, res_count_q;
  logic [7:0]         ch_address_d, ch_address_q, ch_command_d, ch_command_q;
  logic [7:0]         ch_count_d, ch_count_q;
  logic               done_error_d, done_error_q, strobe_d, strobe_q;
  logic [TMO_W-1:0]   tmo_d, tmo_q;
  logic [IDX_W-1:0]   arb_grant_s;
  logic               arb_any_s;
  logic [NUM_REQ-1:0] grant_onehot_s;
  logic               steer_en_s;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
  logic [1:0]         retry_d, retry_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant_s),
    .any_o        (arb_any_s)
  );

  assign grant_onehot_s = ONE << grant_q;
  assign steer_en_s     = (state_q == ST_WAIT_ACTIVE) || (state_q == ST_BUSY);

  // Next-state and output-register logic for the request/complete sequence.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ready_d  = '0;
    done_valid_d = done_valid_q;
    status_d     = status_q;
    res_count_d  = res_count_q;
    ch_address_d = ch_address_q;
    ch_command_d = ch_command_q;
    ch_count_d   = ch_count_q;
    done_error_d = done_error_q;
    strobe_d     = 1'b0;
    tmo_d        = tmo_q;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
    retry_d      = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!ch_active && arb_any_s) begin
          grant_d      = arb_grant_s;
          ch_address_d = addr_a[arb_grant_s];
          ch_command_d = cmd_a[arb_grant_s];
          ch_count_d   = cnt_a[arb_grant_s];
          req_ready_d  = ONE << arb_grant_s;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
          retry_d      = 2'd0;
`endif
          state_d      = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        strobe_d = 1'b1;
        status_d = 8'h00;
        tmo_d    = '0;
        state_d  = ST_WAIT_ACTIVE;
      end
      ST_WAIT_ACTIVE: begin
        if (ch_active) begin
          state_d = ST_BUSY;
        end else if (tmo_q == TMO_W'(START_TIMEOUT)) begin
          done_error_d = 1'b1;
          done_valid_d = grant_onehot_s;
          state_d      = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (ch_status_strobe) begin
          status_d = ch_status;
        end else begin
          status_d = status_q;
        end
        if (!ch_active) begin
          res_count_d = ch_res_count;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
          // A same-cycle status strobe decides the retry, hence status_d.
          if (is_busy(status_d) && (retry_q != 2'(MAX_RETRIES))) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_START;
          end else begin
            done_valid_d = grant_onehot_s;
            state_d      = ST_DONE;
          end
`else
          done_valid_d = grant_onehot_s;
          state_d      = ST_DONE;
`endif
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (done_ready[grant_q]) begin
          done_valid_d = '0;
          done_error_d = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      req_ready_q  <= '0;
      done_valid_q <= '0;
      status_q     <= 8'h00;
      res_count_q  <= 8'h00;
      ch_address_q <= 8'h00;
      ch_command_q <= 8'h00;
      ch_count_q   <= 8'h00;
      done_error_q <= 1'b0;
      strobe_q     <= 1'b0;
      tmo_q        <= '0;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
      retry_q      <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
      status_q     <= status_d;
      res_count_q  <= res_count_d;
      ch_address_q <= ch_address_d;
      ch_command_q <= ch_command_d;
      ch_count_q   <= ch_count_d;
      done_error_q <= done_error_d;
      strobe_q     <= strobe_d;
      tmo_q        <= tmo_d;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  // Stream steering follows the registered grant while the engine may be moving data.
  always_comb begin
    send_tready    = '0;
    recv_tvalid    = '0;
    ch_send_tvalid = 1'b0;
    ch_recv_tready = 1'b0;
    if (steer_en_s) begin
      ch_send_tvalid       = send_tvalid[grant_q];
      send_tready[grant_q] = ch_send_tready;
      recv_tvalid[grant_q] = ch_recv_tvalid;
      ch_recv_tready       = recv_tready[grant_q];
    end else begin
      ch_send_tvalid = 1'b0;
    end
  end

  assign ch_send_tdata   = sdata_a[grant_q];
  assign recv_tdata      = ch_recv_tdata;
  assign req_ready       = req_ready_q;
  assign done_valid      = done_valid_q;
  assign done_status     = status_q;
  assign done_res_count  = res_count_q;
  assign done_error      = done_error_q;
  assign ch_address      = ch_address_q;
  assign ch_command      = ch_command_q;
  assign ch_count        = ch_count_q;
  assign ch_start_strobe = strobe_q;

endmodule

// File: tb/tb_channel_scheduler.sv
// Randomized self-checking bench for channel_scheduler with a behavioural engine and a
// round-robin / completion reference model.
module tb_channel_scheduler;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid, req_ready, done_valid, done_ready;
  logic [8*N-1:0]  req_address, req_command, req_count;
  logic [7:0]      done_status, done_res_count;
  logic            done_error;
  logic [7:0]      ch_address, ch_command, ch_count;
  logic            ch_start_strobe, ch_active, ch_status_strobe;
  logic [7:0]      ch_status, ch_res_count;
  logic [7:0]      ch_send_tdata, ch_recv_tdata, recv_tdata;
  logic            ch_send_tvalid, ch_send_tready, ch_recv_tvalid, ch_recv_tready;
  logic [8*N-1:0]  send_tdata;
  logic [N-1:0]    send_tvalid, send_tready, recv_tvalid, recv_tready;

  channel_scheduler #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_command(req_command), .req_count(req_count),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_status(done_status), .done_res_count(done_res_count), .done_error(done_error),
    .ch_address(ch_address), .ch_command(ch_command), .ch_count(ch_count),
    .ch_start_strobe(ch_start_strobe), .ch_active(ch_active),
    .ch_status(ch_status), .ch_status_strobe(ch_status_strobe), .ch_res_count(ch_res_count),
    .ch_send_tdata(ch_send_tdata), .ch_send_tvalid(ch_send_tvalid), .ch_send_tready(ch_send_tready),
    .ch_recv_tdata(ch_recv_tdata), .ch_recv_tvalid(ch_recv_tvalid), .ch_recv_tready(ch_recv_tready),
    .send_tdata(send_tdata), .send_tvalid(send_tvalid), .send_tready(send_tready),
    .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid), .recv_tready(recv_tready)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         strobe_cnt = 0;
  int         model_last = N - 1;
  logic [7:0] model_res = 8'h00;
  logic [7:0] addr_f [N];
  logic [7:0] cmd_f  [N];
  logic [7:0] cnt_f  [N];
  logic [7:0] data_b [8];

  always @(posedge clk) begin
    if (ch_start_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] one = 1;
    return one << g;
  endfunction

  // Round-robin rule: first pending requester after the last one served, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic load_fields();
    for (int i = 0; i < N; i++) begin
      req_address[8*i +: 8] = addr_f[i];
      req_command[8*i +: 8] = cmd_f[i];
      req_count[8*i +: 8]   = cnt_f[i];
    end
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      addr_f[i] = 8'($urandom);
      cmd_f[i]  = 8'($urandom_range(0, 2));
      cnt_f[i]  = 8'($urandom_range(1, 4));
    end
    for (int i = 0; i < 8; i++) data_b[i] = 8'($urandom);
  endtask

  task automatic write_phase(input int g);
    int k = 0;
    int guard = 0;
    while (k < int'(cnt_f[g]) && guard < 100) begin
      for (int i = 0; i < N; i++) send_tdata[8*i +: 8] = 8'($urandom);
      send_tdata[8*g +: 8] = data_b[k];
      send_tvalid    = '1;
      ch_send_tready = 1'($urandom);
      #1;
      check_eq("send_tvalid", ch_send_tvalid, 1);
      check_eq("send_tdata", ch_send_tdata, data_b[k]);
      check_eq("send_tready", send_tready, ch_send_tready ? oh(g) : '0);
      if (ch_send_tready) k++;
      @(negedge clk);
      guard++;
    end
    send_tvalid    = '0;
    ch_send_tready = 1'b0;
    check_eq("send_count", k, cnt_f[g]);
  endtask

  task automatic read_phase(input int g, input int stall);
    int   k = 0;
    int   j = 0;
    logic rdy;
    while (k < int'(cnt_f[g]) && j < 100) begin
      ch_recv_tvalid = 1'b1;
      ch_recv_tdata  = data_b[k];
      rdy            = (j < stall) ? 1'b0 : 1'b1;
      recv_tready    = rdy ? '1 : ~oh(g);
      #1;
      check_eq("recv_ch_tready", ch_recv_tready, rdy);
      check_eq("recv_tvalid", recv_tvalid, oh(g));
      check_eq("recv_tdata", recv_tdata, data_b[k]);
      if (rdy) k++;
      j++;
      @(negedge clk);
    end
    ch_recv_tvalid = 1'b0;
    recv_tready    = '0;
    check_eq("recv_count", k, cnt_f[g]);
  endtask

  // One full operation: request, start, engine behaviour, completion handshake.
  task automatic run_op(input logic [N-1:0] v, input bit hold, input bit tmo, input int dly,
                        input bit same, input logic [7:0] res,
                        input logic [7:0] st0, input logic [7:0] st1,
                        input logic [7:0] st2, input logic [7:0] st3, input int stall);
    int         g;
    int         s0;
    int         exp_a;
    logic [7:0] st [4];
    st[0] = st0; st[1] = st1; st[2] = st2; st[3] = st3;
    g     = rr_pick(v, model_last);
    s0    = strobe_cnt;
    exp_a = 0;
`ifdef CHANNEL_SCHEDULER_BUSY_RETRY_EN
    while (st[exp_a][3] && exp_a < 3) exp_a++;
`endif
    load_fields();
    req_valid = v;
    @(negedge clk);
    check_eq("req_ready", req_ready, oh(g));
    check_eq("strobe_early", ch_start_strobe, 0);
    check_eq("ch_address", ch_address, addr_f[g]);
    check_eq("ch_command", ch_command, cmd_f[g]);
    check_eq("ch_count", ch_count, cnt_f[g]);
    if (!hold) req_valid = '0;
    @(negedge clk);
    check_eq("strobe", ch_start_strobe, 1);
    check_eq("req_ready_pulse", req_ready, '0);
    if (tmo) begin
      for (int i = 1; i <= TMO + 1; i++) begin
        @(negedge clk);
        if (i == TMO) begin
          check_eq("tmo_error_early", done_error, 0);
          check_eq("tmo_valid_early", done_valid, '0);
        end
      end
      check_eq("tmo_error", done_error, 1);
      check_eq("tmo_valid", done_valid, oh(g));
      check_eq("tmo_status", done_status, 8'h00);
      check_eq("tmo_res", done_res_count, model_res);
      exp_a = 0;
    end else begin
      for (int a = 0; a <= exp_a; a++) begin
        if (a > 0) begin
          check_eq("retry_gap", ch_start_strobe, 0);
          @(negedge clk);
          check_eq("retry_strobe", ch_start_strobe, 1);
        end
        repeat (dly) @(negedge clk);
        ch_active = 1'b1;
        @(negedge clk);
        if (a == 0 && cmd_f[g][0]) write_phase(g);
        if (a == 0 && cmd_f[g][1]) read_phase(g, stall);
        ch_status_strobe = 1'b1;
        ch_status        = 8'($urandom);
        @(negedge clk);
        ch_status = st[a];
        if (!same) begin
          @(negedge clk);
          ch_status_strobe = 1'b0;
        end
        ch_active    = 1'b0;
        ch_res_count = res;
        @(negedge clk);
        ch_status_strobe = 1'b0;
        if (a == exp_a) begin
          check_eq("done_valid", done_valid, oh(g));
          check_eq("done_status", done_status, st[exp_a]);
          check_eq("done_res", done_res_count, res);
          check_eq("done_error", done_error, 0);
        end else begin
          check_eq("retry_no_done", done_valid, '0);
        end
      end
      model_res = res;
    end
    check_eq("strobe_count", strobe_cnt - s0, exp_a + 1);
    done_ready = oh((g + 1) % N);
    @(negedge clk);
    check_eq("done_hold", done_valid, oh(g));
    check_eq("no_grant_in_done", req_ready, '0);
    done_ready = oh(g);
    @(negedge clk);
    check_eq("done_clear", done_valid, '0);
    check_eq("error_clear", done_error, 0);
    done_ready = '0;
    model_last = g;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, '0);
    check_eq({tag, "_done_valid"}, done_valid, '0);
    check_eq({tag, "_status"}, done_status, 8'h00);
    check_eq({tag, "_res"}, done_res_count, 8'h00);
    check_eq({tag, "_error"}, done_error, 0);
    check_eq({tag, "_addr"}, {ch_address, ch_command, ch_count}, 24'h0);
    check_eq({tag, "_strobe"}, ch_start_strobe, 0);
    check_eq({tag, "_steer"}, {send_tready, recv_tvalid, ch_send_tvalid, ch_recv_tready}, '0);
  endtask

  initial begin
    int s0;
    reset_n = 1'b0;
    req_valid = '0; done_ready = '0; req_address = '0; req_command = '0; req_count = '0;
    ch_active = 1'b0; ch_status = 8'h00; ch_status_strobe = 1'b0; ch_res_count = 8'h00;
    ch_send_tready = 1'b0; ch_recv_tdata = 8'h00; ch_recv_tvalid = 1'b0;
    send_tdata = '0; send_tvalid = '0; recv_tready = '0;
    for (int i = 0; i < N; i++) begin addr_f[i] = 8'h00; cmd_f[i] = 8'h00; cnt_f[i] = 8'h01; end
    for (int i = 0; i < 8; i++) data_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Fairness: everyone pending, expect 0,1,2,3,0.
    randomize_fields();
    for (int i = 0; i < 5; i++) begin
      run_op(4'b1111, 1'b1, 1'b0, $urandom_range(0, 3), 1'($urandom), 8'($urandom),
             8'h04, 8'h04, 8'h04, 8'h04, 0);
    end
    req_valid = '0;

    // Single write request from requester 1.
    addr_f[1] = 8'h10; cmd_f[1] = 8'h01; cnt_f[1] = 8'h03;
    run_op(4'b0010, 1'b0, 1'b0, 1, 1'b0, 8'h00, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0);

    // Engine never goes active.
    run_op(4'b1000, 1'b0, 1'b1, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Read with receiver stall on requester 2.
    cmd_f[2] = 8'h02; cnt_f[2] = 8'h02; data_b[0] = 8'hA5; data_b[1] = 8'h5A;
    run_op(4'b0100, 1'b0, 1'b0, 0, 1'b1, 8'h00, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 4);

    // Busy status sequence.
    cmd_f[0] = 8'h00;
    run_op(4'b0001, 1'b0, 1'b0, 1, 1'b0, 8'h02, 8'h08, 8'h08, 8'h0C, 8'h0C, 0);

    // Random traffic.
    for (int it = 0; it < 10; it++) begin
      randomize_fields();
      run_op(4'($urandom_range(1, 15)), 1'b0, (it == 6), $urandom_range(0, 3), 1'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3));
    end

    // Reset while the engine is busy.
    cmd_f[1] = 8'h00;
    load_fields();
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    ch_active = 1'b1;
    send_tvalid = '1; ch_recv_tvalid = 1'b1; recv_tready = '1; ch_send_tready = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    send_tvalid = '0; ch_recv_tvalid = 1'b0; recv_tready = '0; ch_send_tready = 1'b0;
    model_last = N - 1;
    model_res  = 8'h00;
    s0 = strobe_cnt;
    req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("wait_engine_idle", req_ready, '0);
    end
    check_eq("no_strobe_while_active", strobe_cnt - s0, 0);
    ch_active = 1'b0;
    randomize_fields();
    run_op(4'b0100, 1'b0, 1'b0, 0, 1'b1, 8'h07, 8'h01, 8'h01, 8'h01, 8'h01, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
